// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode CSR file with single external interrupt and trap entry/return
module csr_trap_unit (
    input  logic        clk,
    input  logic        csr_reset,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wd,
    input  logic [31:0] pc,
    input  logic        int_req,
    input  logic        int_taken,
    input  logic        mret,
    output logic [31:0] csr_rd,
    output logic [31:0] mtvec,
    output logic [31:0] mepc,
    output logic        int_pending
);
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [31:0] CAUSE_EXT_INT = 32'h8000_000B;
    localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;

    logic        mie;
    logic        mpie;
    logic        pend;
    logic        int_req_q;
    logic [31:0] mscratch;
    logic [31:0] mcause;
    logic        int_rise;

    assign int_rise    = int_req & ~int_req_q;
    assign int_pending = pend & mie;

    // Trap entry owns mstatus/mepc/mcause; mret owns mstatus; CSR writes fill in the rest.
    always_ff @(posedge clk) begin
        if (csr_reset) begin
            mie       <= 1'b0;
            mpie      <= 1'b0;
            pend      <= 1'b0;
            int_req_q <= 1'b0;
            mtvec     <= 32'h0;
            mscratch  <= 32'h0;
            mepc      <= 32'h0;
            mcause    <= 32'h0;
        end else begin
            int_req_q <= int_req;

            if (int_rise) begin
                pend <= 1'b1;
            end else if (int_taken) begin
                pend <= 1'b0;
            end

            if (int_taken) begin
                mepc   <= pc & WORD_MASK;
                mpie   <= mie;
                mie    <= 1'b0;
                mcause <= CAUSE_EXT_INT;
            end else if (mret) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end

            if (csr_we) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        if (!int_taken && !mret) begin
                            mie  <= csr_wd[3];
                            mpie <= csr_wd[7];
                        end
                    end
                    ADDR_MTVEC:    mtvec    <= csr_wd & WORD_MASK;
                    ADDR_MSCRATCH: mscratch <= csr_wd;
                    ADDR_MEPC: begin
                        if (!int_taken) mepc <= csr_wd & WORD_MASK;
                    end
                    ADDR_MCAUSE: begin
                        if (!int_taken) mcause <= csr_wd;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        csr_rd = 32'h0;
        case (csr_addr)
            ADDR_MSTATUS:  csr_rd = {24'h0, mpie, 3'b000, mie, 3'b000};
            ADDR_MTVEC:    csr_rd = mtvec;
            ADDR_MSCRATCH: csr_rd = mscratch;
            ADDR_MEPC:     csr_rd = mepc;
            ADDR_MCAUSE:   csr_rd = mcause;
            ADDR_MIP:      csr_rd = {20'h0, pend, 11'h0};
            default:       csr_rd = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb/tb_csr_trap_unit.sv - directed scenarios plus randomized run against a CSR reference model
module tb_csr_trap_unit;
    logic        clk = 1'b0;
    logic        csr_reset;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wd;
    logic [31:0] pc;
    logic        int_req;
    logic        int_taken;
    logic        mret;
    logic [31:0] csr_rd;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        int_pending;

    int errors = 0;
    int checks = 0;

    // Reference model: whole-register values as software would see them.
    logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic        m_pend, m_prev;

    logic [11:0] addr_list [8] = '{12'h300, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h344, 12'h7C0, 12'h301};

    always #5 clk = ~clk;

    csr_trap_unit dut (
        .clk(clk), .csr_reset(csr_reset), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wd(csr_wd), .pc(pc), .int_req(int_req), .int_taken(int_taken),
        .mret(mret), .csr_rd(csr_rd), .mtvec(mtvec), .mepc(mepc),
        .int_pending(int_pending)
    );

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_pend ? 32'h800 : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] ns;
        if (csr_reset) begin
            {m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause} = '0;
            m_pend = 1'b0;
            m_prev = 1'b0;
        end else begin
            ns = m_mstatus;
            if (int_taken) begin
                m_mepc   = pc & ~32'd3;
                ns       = m_mstatus[3] ? 32'h80 : 32'h0;
                m_mcause = 32'h8000000B;
            end else if (mret) begin
                ns = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
            end
            if (csr_we) begin
                if (csr_addr == 12'h300 && !int_taken && !mret) ns = csr_wd & 32'h88;
                if (csr_addr == 12'h305) m_mtvec = csr_wd & ~32'd3;
                if (csr_addr == 12'h340) m_mscratch = csr_wd;
                if (csr_addr == 12'h341 && !int_taken) m_mepc = csr_wd & ~32'd3;
                if (csr_addr == 12'h342 && !int_taken) m_mcause = csr_wd;
            end
            m_mstatus = ns;
            if (int_req && !m_prev) m_pend = 1'b1;
            else if (int_taken) m_pend = 1'b0;
            m_prev = int_req;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [11:0] a, input logic [31:0] wd,
                         input logic req, input logic tk, input logic mr);
        csr_we = we; csr_addr = a; csr_wd = wd; int_req = req; int_taken = tk; mret = mr;
    endtask

    task automatic test_reset();
        csr_reset = 1'b1;
        drive(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        pc = 32'h0;
        tick(); tick();
        csr_reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            csr_addr = addr_list[i];
            #1;
            checks++;
            if (csr_rd !== 32'h0) begin
                errors++;
                $display("FAIL reset_read addr=%h got=%h exp=%h", csr_addr, csr_rd, 32'h0);
            end
        end
        checks++;
        if (mtvec !== 32'h0 || mepc !== 32'h0 || int_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got mtvec=%h mepc=%h pend=%b exp 0/0/0", mtvec, mepc, int_pending);
        end
    endtask

    task automatic test_csr_write();
        drive(1'b1, 12'h305, 32'h00001003, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (csr_rd !== 32'h0) begin
            errors++;
            $display("FAIL same_cycle_read got=%h exp=%h", csr_rd, 32'h0);
        end
        tick();
        drive(1'b0, 12'h305, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (csr_rd !== 32'h00001000 || mtvec !== 32'h00001000) begin
            errors++;
            $display("FAIL mtvec_write got rd=%h mtvec=%h exp=%h", csr_rd, mtvec, 32'h00001000);
        end
    endtask

    task automatic test_interrupt_flow();
        drive(1'b1, 12'h300, 32'h00000008, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 12'h300, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        #1;
        checks++;
        if (int_pending !== 1'b1) begin
            errors++;
            $display("FAIL int_pending_after_edge got=%b exp=1", int_pending);
        end
        pc = 32'h00000124;
        drive(1'b0, 12'h342, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        int_taken = 1'b0;
        #1;
        checks++;
        if (mepc !== 32'h124 || csr_rd !== 32'h8000000B || int_pending !== 1'b0) begin
            errors++;
            $display("FAIL trap_entry got mepc=%h mcause=%h pend=%b exp 124/8000000b/0", mepc, csr_rd, int_pending);
        end
        csr_addr = 12'h300;
        #1;
        checks++;
        if (csr_rd !== 32'h80) begin
            errors++;
            $display("FAIL trap_mstatus got=%h exp=%h", csr_rd, 32'h80);
        end
    endtask

    task automatic test_mret();
        drive(1'b0, 12'h300, 32'h0, 1'b1, 1'b0, 1'b1);
        tick();
        mret = 1'b0;
        #1;
        checks++;
        if (csr_rd !== 32'h88) begin
            errors++;
            $display("FAIL mret_mstatus got=%h exp=%h", csr_rd, 32'h88);
        end
        tick(); tick();
        checks++;
        if (int_pending !== 1'b0) begin
            errors++;
            $display("FAIL held_level_no_repend got=%b exp=0", int_pending);
        end
    endtask

    task automatic test_masked();
        drive(1'b1, 12'h300, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 12'h344, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        int_req = 1'b1;
        tick();
        #1;
        checks++;
        if (csr_rd !== 32'h800 || int_pending !== 1'b0) begin
            errors++;
            $display("FAIL masked_pend got mip=%h pend=%b exp 800/0", csr_rd, int_pending);
        end
        drive(1'b1, 12'h300, 32'h8, 1'b1, 1'b0, 1'b0);
        tick();
        csr_we = 1'b0;
        #1;
        checks++;
        if (int_pending !== 1'b1) begin
            errors++;
            $display("FAIL unmask_pending got=%b exp=1", int_pending);
        end
    endtask

    task automatic test_priority();
        drive(1'b1, 12'h300, 32'h8, 1'b0, 1'b0, 1'b0);
        tick();
        pc = 32'h0000_0200;
        drive(1'b1, 12'h300, 32'h88, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 12'h300, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (csr_rd !== 32'h80) begin
            errors++;
            $display("FAIL priority_mstatus got=%h exp=%h", csr_rd, 32'h80);
        end
        drive(1'b1, 12'h342, 32'h0000_1234, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 12'h305, 32'h0000_2002, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 12'h342, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (csr_rd !== 32'h8000000B || mtvec !== 32'h2000) begin
            errors++;
            $display("FAIL priority_partial got mcause=%h mtvec=%h exp 8000000b/2000", csr_rd, mtvec);
        end
    endtask

    task automatic test_reset_mid_trap();
        drive(1'b1, 12'h340, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 12'h340, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        csr_reset = 1'b1;
        pc = 32'h500;
        drive(1'b0, 12'h340, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        csr_reset = 1'b0;
        drive(1'b0, 12'h340, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            csr_addr = addr_list[i];
            #1;
            checks++;
            if (csr_rd !== 32'h0) begin
                errors++;
                $display("FAIL reset_mid_trap addr=%h got=%h exp=%h", csr_addr, csr_rd, 32'h0);
            end
        end
        drive(1'b1, 12'h7C0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 12'h344, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 12'h7C0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (csr_rd !== 32'h0) begin
            errors++;
            $display("FAIL unimpl_write got=%h exp=%h", csr_rd, 32'h0);
        end
        csr_addr = 12'h344;
        #1;
        checks++;
        if (csr_rd !== 32'h0) begin
            errors++;
            $display("FAIL mip_readonly got=%h exp=%h", csr_rd, 32'h0);
        end
    endtask

    task automatic test_random();
        logic [11:0] a;
        for (int n = 0; n < 500; n++) begin
            csr_reset = ($urandom_range(0, 59) == 0);
            a = addr_list[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) == 0) int_req = ~int_req;
            csr_we    = $urandom_range(0, 1);
            csr_addr  = a;
            csr_wd    = $urandom;
            pc        = $urandom;
            int_taken = ($urandom_range(0, 5) == 0);
            mret      = ($urandom_range(0, 5) == 0);
            #1;
            checks++;
            if (csr_rd !== model_read(a) || mtvec !== m_mtvec || mepc !== m_mepc ||
                int_pending !== (m_pend & m_mstatus[3])) begin
                errors++;
                $display("FAIL random n=%0d addr=%h got rd=%h mtvec=%h mepc=%h pend=%b exp rd=%h mtvec=%h mepc=%h pend=%b",
                         n, a, csr_rd, mtvec, mepc, int_pending,
                         model_read(a), m_mtvec, m_mepc, m_pend & m_mstatus[3]);
            end
            tick();
        end
        csr_reset = 1'b0;
    endtask

    initial begin
        csr_reset = 1'b1;
        drive(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        pc = 32'h0;
        @(negedge clk);
        test_reset();
        test_csr_write();
        test_interrupt_flow();
        test_mret();
        test_masked();
        test_priority();
        test_reset_mid_trap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clock or reset SHALL exist.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 csr_reset  input  1  synchronous active-high reset.
REQ-004 csr_we  input  1  CSR write strobe from the control FSM (CSRRW execute state).
REQ-005 csr_addr  input  12  CSR address for both read and write.
REQ-006 csr_wd  input  32  CSR write data (rs1 value).
REQ-007 pc  input  32  address of the next instruction to resume at, captured on trap entry.
REQ-008 int_req  input  1  external interrupt request level, clk-synchronous.
REQ-009 int_taken  input  1  one-cycle strobe from the control FSM when it redirects fetch to mtvec (pcSource 3'b100).
REQ-010 mret  input  1  one-cycle strobe when MRET executes (fetch redirected to mepc, pcSource 3'b101).
REQ-011 csr_rd  output  32  combinational read data for csr_addr.
REQ-012 mtvec  output  32  trap vector address for the PC mux.
REQ-013 mepc  output  32  trap return address for the PC mux.
REQ-014 int_pending  output  1  interrupt ready to be taken, equal to pend AND mstatus.MIE.

Function
REQ-015 CSRs SHALL be: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, and mip 0x344, which SHALL be read-only.
REQ-016 Only mstatus bits 3 (MIE) and 7 (MPIE) SHALL be stored; all other mstatus bits SHALL read 0.
REQ-017 mtvec and mepc bits [1:0] SHALL be forced to 0 on every write path; mscratch and mcause SHALL store all 32 bits.
REQ-018 mip SHALL read {20'b0, pend, 11'b0}, i.e. bit 11 = pend.
REQ-019 Reads of unimplemented addresses SHALL return 32'h0, and writes to them or to mip SHALL be ignored.
REQ-020 csr_rd SHALL reflect current register state, so a read in the same cycle as a write returns the old value and the new value is visible the next cycle.
REQ-021 Edge detect: a registered copy of int_req SHALL be kept, and a rising edge (int_req=1, previous=0) SHALL set pend.
REQ-022 A level held high SHALL NOT re-set pend after it is cleared; a new 0->1 transition is required.
REQ-023 On int_taken, the next edge SHALL apply: mepc<=pc&~3; MPIE<=MIE; MIE<=0; mcause<=32'h8000000B; pend<=0.
REQ-024 On mret, the next edge SHALL apply: MIE<=MPIE; MPIE<=1.
REQ-025 On a rising edge of int_req coincident with int_taken, pend SHALL end at 1 (set wins).
REQ-026 Same-cycle priority SHALL be int_taken > mret > csr_we; a lower-priority update SHALL be dropped only for the registers the higher one modifies.
REQ-027 csr_we targeting mtvec, mscratch or mcause alongside int_taken/mret SHALL still take effect unless that register is modified by the higher-priority event (mcause on int_taken).
REQ-028 int_taken when int_pending=0 SHALL still perform the REQ-023 update (the controller owns the decision).
REQ-029 int_pending SHALL be combinational from registered state with no input-to-output path.

Reset
REQ-030 With csr_reset=1 at a rising edge, mstatus, mtvec, mscratch, mepc, mcause, pend and the int_req history register SHALL become 0; reset SHALL override all other inputs that cycle.
REQ-031 After reset, mtvec=0, mepc=0, int_pending=0, and csr_rd SHALL be 0 for every address.
REQ-032 Reset asserted mid-trap (same cycle as int_taken or mret) SHALL yield reset values only.

Verification
REQ-033 Scenario: write 0x305 with 0x00001003 -> next cycle mtvec=0x00001000 and csr_rd@0x305=0x00001000; the same-cycle read returns 0.
REQ-034 Scenario: write mstatus 0x00000008, pulse int_req 0->1 -> int_pending=1 one cycle later; int_taken with pc=0x00000124 -> mepc=0x124, mcause=0x8000000B, mstatus=0x80, int_pending=0.
REQ-035 Scenario: after REQ-034, pulse mret -> mstatus=0x88; int_req held high throughout -> int_pending stays 0.
REQ-036 Scenario: MIE=0, int_req edge -> csr_rd@0x344=0x800 and int_pending=0; then write mstatus=8 -> int_pending=1.
REQ-037 Scenario: int_taken, mret and csr_we to mstatus (0x88) in the same cycle -> int_taken result wins (MIE=0, MPIE=old MIE).
REQ-038 Scenario: csr_reset during int_taken with registers nonzero -> all CSRs read 0 the next cycle; write to 0x7C0 -> read 0.
